// File: rtl/control_ascensor.sv
// control_ascensor: SCAN (collective-selective) controller for a 4-floor car.
// Latches call buttons into a pending-request register, moves the car floor by
// floor, opens the door and clears serviced requests.
// Optional feature macro: ASCENSOR_PUERTA_EXT_EN adds the boton_abrir door-hold input.
// Request bit map (botones/pisos): [3:0] cabin floor 0-3, [6:4] hall UP floor 0-2,
// [9:7] hall DOWN floor 1-3.
// estado = {moving, direction (1 up), floor[1:0]}; it is also the observable view
// of the FSM: moving=1 <=> MOVIENDO, puerta_abierta=1 <=> PUERTA, else REPOSO.
module control_ascensor #(
  parameter int T_VIAJE  = 20,
  parameter int T_PUERTA = 30,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] botones,
`ifdef ASCENSOR_PUERTA_EXT_EN
  input  logic       boton_abrir,
`endif
  output logic [9:0] pisos,
  output logic [3:0] estado,
  output logic       motor_subir,
  output logic       motor_bajar,
  output logic       puerta_abierta
);

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    MOVIENDO = 2'd1,
    PUERTA   = 2'd2
  } fsm_t;

  localparam logic [CW-1:0] VIAJE_FIN  = CW'(T_VIAJE - 1);
  localparam logic [CW-1:0] PUERTA_FIN = CW'(T_PUERTA - 1);

  // All request bits that belong to floor f
  function automatic logic [9:0] m_floor(input logic [1:0] f);
    case (f)
      2'd0:    m_floor = 10'h011;
      2'd1:    m_floor = 10'h0A2;
      2'd2:    m_floor = 10'h144;
      default: m_floor = 10'h208;
    endcase
  endfunction

  // Request bits for floors strictly above f
  function automatic logic [9:0] m_above(input logic [1:0] f);
    case (f)
      2'd0:    m_above = 10'h3EE;
      2'd1:    m_above = 10'h34C;
      2'd2:    m_above = 10'h208;
      default: m_above = 10'h000;
    endcase
  endfunction

  // Request bits for floors strictly below f
  function automatic logic [9:0] m_below(input logic [1:0] f);
    case (f)
      2'd0:    m_below = 10'h000;
      2'd1:    m_below = 10'h011;
      2'd2:    m_below = 10'h0B3;
      default: m_below = 10'h1F7;
    endcase
  endfunction

  // Cabin button bit of floor f
  function automatic logic [9:0] m_cab(input logic [1:0] f);
    case (f)
      2'd0:    m_cab = 10'h001;
      2'd1:    m_cab = 10'h002;
      2'd2:    m_cab = 10'h004;
      default: m_cab = 10'h008;
    endcase
  endfunction

  // Hall button bit of floor f for direction d (1 up, 0 down); none at the ends
  function automatic logic [9:0] m_hall(input logic [1:0] f, input logic d);
    if (d) begin
      case (f)
        2'd0:    m_hall = 10'h010;
        2'd1:    m_hall = 10'h020;
        2'd2:    m_hall = 10'h040;
        default: m_hall = 10'h000;
      endcase
    end else begin
      case (f)
        2'd0:    m_hall = 10'h000;
        2'd1:    m_hall = 10'h080;
        2'd2:    m_hall = 10'h100;
        default: m_hall = 10'h200;
      endcase
    end
  endfunction

  fsm_t          state_q, state_n;
  logic [1:0]    floor_q, floor_n;
  logic          dir_q, dir_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [9:0]    pisos_q, pisos_n;
  logic          moving_q, moving_n;
  logic          sub_q, sub_n;
  logic          baj_q, baj_n;
  logic          door_q, door_n;

  logic          abrir;
  logic [1:0]    nf;
  logic          here_any, above_any, below_any;
  logic          ahead_here, behind_here;
  logic          ahead_nf, stop_nf, opp_nf, edge_blocked;
  logic [9:0]    clr_nf, absorb;

`ifdef ASCENSOR_PUERTA_EXT_EN
  assign abrir = boton_abrir;
`else
  assign abrir = 1'b0;
`endif

  // Floor reached at the end of the current one-floor trip
  assign nf = dir_q ? (floor_q + 2'd1) : (floor_q - 2'd1);

  assign here_any    = (pisos_q & m_floor(floor_q)) != 10'h000;
  assign above_any   = (pisos_q & m_above(floor_q)) != 10'h000;
  assign below_any   = (pisos_q & m_below(floor_q)) != 10'h000;
  assign ahead_here  = dir_q ? above_any : below_any;
  assign behind_here = dir_q ? below_any : above_any;

  // Arrival decision: stop for cabin, same-direction hall, or opposite hall at the turn
  assign ahead_nf = (pisos_q & (dir_q ? m_above(nf) : m_below(nf))) != 10'h000;
  assign opp_nf   = !ahead_nf && ((pisos_q & m_hall(nf, !dir_q)) != 10'h000);
  assign stop_nf  = ((pisos_q & (m_cab(nf) | m_hall(nf, dir_q))) != 10'h000) || opp_nf;
  assign clr_nf   = m_cab(nf) | m_hall(nf, dir_q) | (opp_nf ? m_hall(nf, !dir_q) : 10'h000);

  // A trip past the top or bottom floor is never started
  assign edge_blocked = (dir_q && floor_q == 2'd3) || (!dir_q && floor_q == 2'd0);

  // Presses at the open floor that match the served direction only extend the door
  assign absorb = botones & (m_cab(floor_q) | m_hall(floor_q, dir_q));

  // State register, request register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= REPOSO;
      floor_q  <= 2'd0;
      dir_q    <= 1'b1;
      cnt_q    <= '0;
      pisos_q  <= 10'h000;
      moving_q <= 1'b0;
      sub_q    <= 1'b0;
      baj_q    <= 1'b0;
      door_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      floor_q  <= floor_n;
      dir_q    <= dir_n;
      cnt_q    <= cnt_n;
      pisos_q  <= pisos_n;
      moving_q <= moving_n;
      sub_q    <= sub_n;
      baj_q    <= baj_n;
      door_q   <= door_n;
    end
  end

  // Next-state logic: SCAN scheduling, trip/door timing and request latching
  always_comb begin
    state_n = state_q;
    floor_n = floor_q;
    dir_n   = dir_q;
    cnt_n   = cnt_q;
    pisos_n = pisos_q | botones;
    case (state_q)
      REPOSO: begin
        cnt_n = '0;
        if (here_any || abrir) begin
          state_n = PUERTA;
          pisos_n = (pisos_q | botones) & ~m_floor(floor_q);
        end else if (above_any) begin
          state_n = MOVIENDO;
          dir_n   = 1'b1;
        end else if (below_any) begin
          state_n = MOVIENDO;
          dir_n   = 1'b0;
        end
      end
      MOVIENDO: begin
        if (edge_blocked) begin
          state_n = REPOSO;
          cnt_n   = '0;
        end else if (cnt_q == VIAJE_FIN) begin
          cnt_n   = '0;
          floor_n = nf;
          if (stop_nf) begin
            state_n = PUERTA;
            pisos_n = (pisos_q | botones) & ~clr_nf;
            if (opp_nf) dir_n = !dir_q;
          end else if (!ahead_nf) begin
            state_n = REPOSO;
          end
          if (nf == 2'd3) dir_n = 1'b0;
          if (nf == 2'd0) dir_n = 1'b1;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      PUERTA: begin
        pisos_n = pisos_q | (botones & ~absorb);
        if (absorb != 10'h000 || abrir) begin
          cnt_n = '0;
        end else if (cnt_q == PUERTA_FIN) begin
          cnt_n = '0;
          if (ahead_here) begin
            state_n = MOVIENDO;
          end else if (behind_here) begin
            state_n = MOVIENDO;
            dir_n   = !dir_q;
          end else begin
            state_n = REPOSO;
          end
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: begin
        state_n = REPOSO;
        cnt_n   = '0;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    moving_n = (state_n == MOVIENDO);
    sub_n    = moving_n && dir_n;
    baj_n    = moving_n && !dir_n;
    door_n   = (state_n == PUERTA);
  end

  assign pisos          = pisos_q;
  assign estado         = {moving_q, dir_q, floor_q};
  assign motor_subir    = sub_q;
  assign motor_bajar    = baj_q;
  assign puerta_abierta = door_q;

endmodule

// File: tb/tb_control_ascensor.sv
// Directed bench for control_ascensor with T_VIAJE=4, T_PUERTA=3.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_control_ascensor;

  logic       clk;
  logic       reset;
  logic [9:0] botones;
`ifdef ASCENSOR_PUERTA_EXT_EN
  logic       boton_abrir;
`endif
  logic [9:0] pisos;
  logic [3:0] estado;
  logic       motor_subir;
  logic       motor_bajar;
  logic       puerta_abierta;

  int checks   = 0;
  int failures = 0;
  bit run_safety = 1'b0;

  control_ascensor #(
    .T_VIAJE  (4),
    .T_PUERTA (3),
    .CW       (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .botones        (botones),
`ifdef ASCENSOR_PUERTA_EXT_EN
    .boton_abrir    (boton_abrir),
`endif
    .pisos          (pisos),
    .estado         (estado),
    .motor_subir    (motor_subir),
    .motor_bajar    (motor_bajar),
    .puerta_abierta (puerta_abierta)
  );

  // Clock: 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Motor/door exclusion watched on every falling edge once reset has settled
  always @(negedge clk) begin
    if (run_safety) begin
      check("motors_exclusive", {31'd0, motor_subir & motor_bajar}, 32'd0);
      check("motor_with_door", {31'd0, (motor_subir | motor_bajar) & puerta_abierta}, 32'd0);
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset   = 1'b1;
    botones = 10'h000;
`ifdef ASCENSOR_PUERTA_EXT_EN
    boton_abrir = 1'b0;
`endif
    tick(2);
    reset = 1'b0;
    run_safety = 1'b1;
    check("rst_pisos", pisos, 10'h000);
    check("rst_estado", estado, 4'b0100);
    check("rst_motors", {motor_subir, motor_bajar}, 2'b00);
    check("rst_door", puerta_abierta, 1'b0);

    tick(100);
    check("idle_pisos", pisos, 10'h000);
    check("idle_estado", estado, 4'b0100);
    check("idle_out", {motor_subir, motor_bajar, puerta_abierta}, 3'b000);

    // Cabin call to floor 2 from floor 0
    botones = 10'h004;
    tick(1);
    botones = 10'h000;
    check("latch_p2", pisos, 10'h004);
    check("latch_still_idle", estado, 4'b0100);
    tick(1);
    check("up_start_estado", estado, 4'b1100);
    check("up_start_motor", motor_subir, 1'b1);
    tick(3);
    check("up_f0_hold", estado, 4'b1100);
    tick(1);
    check("up_f1", estado, 4'b1101);
    n = 0;
    while (motor_subir && n < 40) begin
      n++;
      tick(1);
    end
    check("up_motor_rest_cycles", n, 4);
    check("arr_f2_estado", estado, 4'b0110);
    check("arr_f2_door", puerta_abierta, 1'b1);
    check("arr_f2_pisos", pisos, 10'h000);
    n = 0;
    while (puerta_abierta && n < 40) begin
      n++;
      tick(1);
    end
    check("door_cycles", n, 3);
    check("f2_reposo", {estado, motor_subir, motor_bajar}, {4'b0110, 2'b00});
    tick(5);
    check("f2_stays", {estado, puerta_abierta}, {4'b0110, 1'b0});

    // Back down to floor 0
    botones = 10'h001;
    tick(1);
    botones = 10'h000;
    check("latch_p0", pisos, 10'h001);
    tick(1);
    check("down_start", {estado, motor_bajar}, {4'b1010, 1'b1});
    tick(4);
    check("down_f1", estado, 4'b1001);
    tick(4);
    check("arr_f0_estado", estado, 4'b0100);
    check("arr_f0_door", puerta_abierta, 1'b1);
    check("arr_f0_pisos", pisos, 10'h000);

    // Same-floor cabin press while door open: absorbed, door restarts
    tick(1);
    botones = 10'h001;
    tick(1);
    botones = 10'h000;
    check("absorb_pisos", pisos, 10'h000);
    check("absorb_door", puerta_abierta, 1'b1);
    tick(1);
    check("restart_door_a", puerta_abierta, 1'b1);
    tick(1);
    check("restart_door_b", puerta_abierta, 1'b1);
    tick(1);
    check("restart_close", {estado, puerta_abierta}, {4'b0100, 1'b0});

    // Cabin 3 plus hall DOWN@2: skip 2 going up, serve 3, come back to 2
    botones = 10'h108;
    tick(1);
    botones = 10'h000;
    check("latch_108", pisos, 10'h108);
    tick(1);
    check("scan_up", estado, 4'b1100);
    tick(4);
    check("scan_f1", estado, 4'b1101);
    tick(4);
    check("scan_skip_f2", {estado, puerta_abierta}, {4'b1110, 1'b0});
    check("scan_skip_pisos", pisos, 10'h108);
    tick(4);
    check("scan_f3", {estado, puerta_abierta}, {4'b0011, 1'b1});
    check("scan_f3_pisos", pisos, 10'h100);
    tick(3);
    check("scan_reverse", {estado, motor_bajar, puerta_abierta}, {4'b1011, 1'b1, 1'b0});
    tick(4);
    check("scan_f2_down", {estado, puerta_abierta}, {4'b0010, 1'b1});
    check("scan_f2_pisos", pisos, 10'h000);
    tick(3);
    check("scan_done", {estado, puerta_abierta}, {4'b0010, 1'b0});

    // Reset while travelling between floors 2 and 1
    botones = 10'h011;
    tick(1);
    botones = 10'h000;
    check("latch_011", pisos, 10'h011);
    tick(1);
    check("mid_start", estado, 4'b1010);
    tick(2);
    check("mid_travel", {estado, motor_bajar}, {4'b1010, 1'b1});
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midrst_pisos", pisos, 10'h000);
    check("midrst_estado", estado, 4'b0100);
    check("midrst_out", {motor_subir, motor_bajar, puerta_abierta}, 3'b000);
    tick(10);
    check("midrst_lost", {pisos, estado}, {10'h000, 4'b0100});

`ifdef ASCENSOR_PUERTA_EXT_EN
    // Door-hold: open from REPOSO, hold 10 cycles, then normal close
    boton_abrir = 1'b1;
    tick(1);
    n = puerta_abierta ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (puerta_abierta) n++;
    end
    boton_abrir = 1'b0;
    for (int i = 0; i < 40 && puerta_abierta; i++) begin
      tick(1);
      if (puerta_abierta) n++;
    end
    check("hold_door_cycles", n, 13);
    check("hold_done", {estado, puerta_abierta}, {4'b0100, 1'b0});
`endif

    run_safety = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_ascensor.md
# control_ascensor

Elevator controller for a 4-floor car: latches the ten call buttons into a pending-request register and runs the SCAN (collective-selective) FSM that moves the car, opens the door and clears serviced requests. Directly upstream of `INTERFAZ_SALIDA`: its `pisos` and `estado` outputs drive that block's `pisos` and `estado` inputs unchanged.

## Interface
- `T_VIAJE`, 20: cycles to travel one floor (≥1).
- `T_PUERTA`, 30: cycles the door stays open (≥1).
- `CW`, 8: width of the shared travel/door counter; must hold max(T_VIAJE, T_PUERTA).

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `botones`  in  10  button pulses: [3:0] cabin buttons for floors 0–3; [6:4] hall UP on floors 0–2; [9:7] hall DOWN on floors 1–3.
- `boton_abrir`  in  1  door-hold button (present only with `ASCENSOR_PUERTA_EXT_EN`).
- `pisos`  out  10  pending requests, same bit map as `botones`.
- `estado`  out  4  [1:0] current floor, [2] direction (1 up, 0 down), [3] moving.
- `motor_subir`  out  1  motor up command.
- `motor_bajar`  out  1  motor down command.
- `puerta_abierta`  out  1  door open.

## Operation
- Reset values: `pisos`=0, floor=0, direction=1, moving=0, motors=0, door=0, counter=0, FSM=REPOSO.
- Request latch: `pisos` |= `botones` every cycle, except button bits for the current floor while in PUERTA (absorbed; see below). Clearing a bit and a new press of the same bit in the same cycle: clear wins.
- "Ahead" = any pending bit (cabin or hall) for a floor strictly beyond the current one in the current direction.
- REPOSO: if any request at current floor → PUERTA, clear all three bits of that floor. Else if requests above → direction=1, MOVIENDO. Else if below → direction=0, MOVIENDO. Else stay.
- MOVIENDO: `estado[3]`=1, matching motor on; counter counts to T_VIAJE−1, then floor ±1, counter=0. On arrival stop (→ PUERTA) if cabin bit of that floor set, or hall bit in travel direction set, or no requests ahead and the opposite-direction hall bit is set; clear cabin bit plus the hall bit(s) served (opposite hall bit served only in the no-requests-ahead case, and then direction flips). Otherwise keep moving.
- PUERTA: `puerta_abierta`=1, motors off, moving=0; counter to T_PUERTA−1. Presses of current-floor buttons that match the direction just served restart the counter instead of latching. At expiry: requests ahead → MOVIENDO same direction; else requests behind → flip direction, MOVIENDO; else REPOSO.
- Boundaries: never move up from floor 3 or down from floor 0; direction forced to 0 on arrival at floor 3 and to 1 at floor 0.
- `motor_subir` and `motor_bajar` never both 1; motor never on while door open.
- Reset mid-motion: all state returns to reset values next edge; pending requests lost.

## Timing
- Button press at cycle n → `pisos` bit visible at n+1.
- REPOSO → MOVIENDO decision in 1 cycle; floor changes exactly T_VIAJE cycles after entering MOVIENDO (or after previous floor step).
- Arrival and door open occur on the same edge as the floor update; serviced bits clear on that edge.
- Door open exactly T_PUERTA cycles absent restarts.
- All outputs registered.

## Configuration
- `ASCENSOR_PUERTA_EXT_EN` defined: `boton_abrir` port exists; while in PUERTA a high level holds counter at 0 (door stays open); in REPOSO a press opens the door at current floor for T_PUERTA.
- Undefined: no `boton_abrir` port; door timing purely T_PUERTA plus same-floor button restarts.

## Test plan
- Reset, then idle 100 cycles → `pisos`=0, `estado`=4'b0100, motors/door 0.
- T_VIAJE=4, T_PUERTA=3; pulse `botones`[2] at floor 0 → `pisos`=10'h004 next cycle, up motor 8 cycles, floor 2, door 3 cycles, `pisos`=0, REPOSO.
- Car moving up past floor 1 with `botones`[8] (DOWN@2) and `botones`[3] pending → skips floor 2, serves 3, reverses, stops at 2, clears bit 8.
- Press `botones`[0] while door open at floor 0 → bit not latched, door counter restarts.
- Assert `reset` mid-travel between floors 1 and 2 → next edge all outputs at reset values.
- With `ASCENSOR_PUERTA_EXT_EN`: hold `boton_abrir` 10 cycles in PUERTA → door open 10+T_PUERTA cycles.
